matrix_result_writer: RTL
=========================

// Module: matrix_result_writer
// PURPOSE
//  Downstream of the 2x2 matrix-multiply stage. Captures the four 32-bit products
//  (p00,p01,p10,p11) on a valid/ready handshake and post-processes each one:
//  optional ReLU, arithmetic right shift, optional clamp. Writes the four results
//  as consecutive words into the data memory through a backpressured write port.
//  Signals completion so that software or the core can read the results back.
// PARAMETERS
//  ADDR_W  8   word-address width of the data-memory write port
//  SHIFT   0   arithmetic right shift applied after ReLU (0..31)
//  SAT_W   16  signed clamp width, used only when MRW_SAT_EN is defined (2..32)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous, active-low reset
//  relu_en    in   1       1: negative results (bit31 set) become 0; sampled at capture
//  in_valid   in   1       p00..p11 and base_addr are valid this cycle
//  in_ready   out  1       1 only in IDLE; a transfer happens when in_valid&&in_ready
//  p00..p11   in   32 ea   matrix products, treated as signed two's complement
//  base_addr  in   ADDR_W  word address for p00; p01/p10/p11 go to +1/+2/+3
//  mem_we     out  1       write request
//  mem_addr   out  ADDR_W  word address of the write
//  mem_wdata  out  32      write data
//  mem_ready  in   1       memory accepts the write when mem_we&&mem_ready
//  busy       out  1       1 from capture until the 4th write is accepted
//  done       out  1       single-cycle pulse after the 4th accepted write
//  sat_flag   out  1       sticky: some captured value was clamped; cleared on next capture
//  wr_count   out  16      count of accepted words, wraps at 2^16
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; done=0;
//   sat_flag=0; wr_count=0. Reset in mid-operation aborts the transfer and masks
//   mem_we starting the cycle after rst_n is sampled low. No partial write completes.
//  FSM: IDLE -> WRITE on in_valid&&in_ready. WRITE stays until idx==3 && mem_we&&mem_ready,
//   then goes to DONE. DONE lasts one cycle (done=1) and returns to IDLE.
//  Capture at edge t: all four post-processed words, base_addr and idx=0 are registered.
//   From cycle t+1: mem_we=1, mem_addr=base_addr, mem_wdata=word0.
//  Word k advances on mem_we&&mem_ready. Address = base_addr+k, mod 2^ADDR_W (wraps).
//   With no backpressure: 4 consecutive write cycles, done in the 5th cycle, and
//   in_ready=1 again in the 6th cycle after capture.
//  While mem_ready=0, mem_addr, mem_wdata and mem_we stay stable.
//  in_valid outside IDLE is ignored; upstream must hold it until in_ready.
//  Post-processing order, per word: ReLU (if relu_en) -> >>>SHIFT -> clamp (if MRW_SAT_EN).
//  wr_count increments once per accepted write.
// CONFIGURATION
//  MRW_SAT_EN defined: clamp each word to [-(2^(SAT_W-1)), 2^(SAT_W-1)-1], sign-extended
//   to 32 bits. sat_flag is set if any of the four words was clamped.
//  MRW_SAT_EN undefined: the shifted value passes through unchanged; sat_flag is tied to 0.
// STRUCTURE
//  Package mrw_pkg: state enum {IDLE,WRITE,DONE}, NUM_WORDS=4, IDX_W=2.
//  Sub-module mrw_post: combinational ReLU/shift/clamp for one word, with a sat output.
//   Four instances, one per product, feed the capture registers.
// TESTING
//  Reset: hold rst_n=0 for 2 clk -> in_ready=1, mem_we=0, wr_count=0, busy=0.
//  p=1,2,3,4, base=0x10, mem_ready=1, relu_en=0 -> writes (0x10,1)(0x11,2)(0x12,3)
//   (0x13,4) on 4 consecutive cycles; done=1 next cycle; wr_count=4.
//  Same transfer with mem_ready=0 for 3 cycles on word 1 -> addr 0x11 and data 2 held
//   stable; done 8 cycles after capture; base=0xFE run -> addrs FE,FF,00,01.
//  p00=0xFFFFFFF0: relu_en=1 -> word 0x00000000; relu_en=0 -> 0xFFFFFFF0 (SHIFT=0).
//  MRW_SAT_EN, SAT_W=16: p01=0x00020000 -> 0x00007FFF and sat_flag=1; the next capture
//   with small values -> sat_flag=0. Without the macro -> 0x00020000 and sat_flag=0.
//  rst_n=0 after 2nd accepted write -> mem_we=0 next cycle, in_ready=1, wr_count=0.

Source files
------------

// File: rtl/mrw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mrw_pkg                                                         |
// | Brief    : Shared types and sizes for the matrix result writer.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mrw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_WORDS = 4;
  localparam int IDX_W     = 2;

endpackage
`default_nettype wire

// File: rtl/mrw_post.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mrw_post                                                        |
// | Brief    : Combinational post-processing of one product:                   |
// |            ReLU -> arithmetic right shift -> optional signed clamp.        |
// |            Clamp present only when MRW_SAT_EN is defined.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mrw_post #(
  parameter int SHIFT = 0
`ifdef MRW_SAT_EN
  ,
  parameter int SAT_W = 16
`endif
) (
  input  logic [31:0] p,
  input  logic        relu_en,
  output logic [31:0] word,
  output logic        sat
);

  logic signed [31:0] relu_v;
  logic signed [31:0] shift_v;

  assign relu_v  = (relu_en && p[31]) ? 32'sd0 : $signed(p);
  assign shift_v = relu_v >>> SHIFT;

`ifdef MRW_SAT_EN
  // Limits held at 33 bits so SAT_W=32 still has a representable maximum.
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (SAT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (SAT_W - 1));

  logic signed [32:0] ext_v;
  assign ext_v = {shift_v[31], shift_v};

  // Clamp the shifted value into the SAT_W signed range and flag any clipping.
  always_comb begin
    word = shift_v;
    sat  = 1'b0;
    if (ext_v > MAX_V) begin
      word = MAX_V[31:0];
      sat  = 1'b1;
    end else if (ext_v < MIN_V) begin
      word = MIN_V[31:0];
      sat  = 1'b1;
    end
  end
`else
  assign word = shift_v;
  assign sat  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/matrix_result_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matrix_result_writer                                            |
// | Brief    : Captures four 2x2 matrix products, post-processes them and      |
// |            writes them as consecutive words through a backpressured        |
// |            memory write port. Optional clamp enabled by MRW_SAT_EN.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matrix_result_writer
  import mrw_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SHIFT  = 0,
  parameter int SAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       p00,
  input  logic [31:0]       p01,
  input  logic [31:0]       p10,
  input  logic [31:0]       p11,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [15:0]       wr_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       prods     [NUM_WORDS];
  logic [31:0]       post_word [NUM_WORDS];
  logic [NUM_WORDS-1:0] post_sat;
  logic [31:0]       words     [NUM_WORDS];
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx;
  logic              capture;
  logic              accept;

  // Out-of-range clamp widths surface as this named scope in the hierarchy.
  if (SAT_W < 2 || SAT_W > 32) begin : g_sat_w_out_of_range
  end

  assign prods[0] = p00;
  assign prods[1] = p01;
  assign prods[2] = p10;
  assign prods[3] = p11;

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_post
    mrw_post #(
      .SHIFT (SHIFT)
`ifdef MRW_SAT_EN
      ,
      .SAT_W (SAT_W)
`endif
    ) u_post (
      .p       (prods[i]),
      .relu_en (relu_en),
      .word    (post_word[i]),
      .sat     (post_sat[i])
    );
  end

  assign in_ready  = (state == IDLE);
  assign mem_we    = (state == WRITE);
  assign busy      = (state == WRITE);
  assign done      = (state == DONE);
  assign capture   = in_valid && in_ready;
  assign accept    = mem_we && mem_ready;
  assign mem_addr  = base_q + ADDR_W'(idx);
  assign mem_wdata = words[idx];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: capture starts writing, last accepted word finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = WRITE;
      WRITE:   if (idx == LAST_IDX && mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the processed words on handshake; step the word index on each accepted write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
      base_q   <= '0;
      idx      <= '0;
      sat_flag <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < NUM_WORDS; i++) words[i] <= post_word[i];
      base_q   <= base_addr;
      idx      <= '0;
      sat_flag <= |post_sat;
    end else if (accept && idx != LAST_IDX) begin
      idx <= idx + 1'b1;
    end
  end

  // Running count of accepted words, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)      wr_count <= '0;
    else if (accept) wr_count <= wr_count + 16'd1;
  end

endmodule
`default_nettype wire
